mem_arbiter: RTL and testbench

Two-port access controller for the coprocessor's block memory. It arbitrates between the host interface and the coprocessor core and sequences each transaction into the memory's single read/write port. It owns all writes to the status word (cell 1) and gates core access using the config word (cell 0). It sits between both requesters and the memory instance; nothing else drives the memory's enables.

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: host/core arbiter sequencing transactions into the block memory port and writing the status word; define MEM_ARB_ROUND_ROBIN_EN for round-robin, else fixed host priority
module mem_arbiter #(
    parameter int size       = 1024,
    parameter int blocks     = 4,
    parameter int log_size   = 10,
    parameter int cell_width = 32,
    parameter int width      = blocks * cell_width
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic                  in_host_req,
    input  logic                  in_host_we,
    input  logic [log_size-1:0]   in_host_addr,
    input  logic [width-1:0]      in_host_wdata,
    input  logic                  in_core_req,
    input  logic                  in_core_we,
    input  logic [log_size-1:0]   in_core_addr,
    input  logic [width-1:0]      in_core_wdata,
    output logic                  out_host_ack,
    output logic                  out_host_err,
    output logic [width-1:0]      out_host_rdata,
    output logic                  out_core_ack,
    output logic                  out_core_err,
    output logic [width-1:0]      out_core_rdata,
    output logic [log_size-1:0]   out_mem_address,
    output logic [width-1:0]      out_mem_data,
    output logic                  out_mem_read_en,
    output logic                  out_mem_write_en,
    output logic [cell_width-1:0] out_mem_status,
    output logic                  out_mem_write_status_en,
    input  logic [width-1:0]      in_mem_data,
    input  logic [cell_width-1:0] in_mem_config,
    output logic                  out_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [log_size-1:0] max_addr = log_size'(size - blocks);
    state_t state, state_nxt;
    logic host_ok, core_ok, pick_core, start, sel_we, req_err, done;
    logic [log_size-1:0] sel_addr;
    logic we_r, grant_r, err_r;
    logic [width-1:0] rdata_r;
    logic [15:0] txn_count;
    logic unused_cfg;
    assign unused_cfg = ^in_mem_config[cell_width-1:1];
    assign host_ok = in_host_req;
    assign core_ok = in_core_req & in_mem_config[0];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;
    assign pick_core = core_ok & (~host_ok | ~last_grant);
    // remember who won last so a contested IDLE favours the other side
    always_ff @(posedge in_clk) begin
        if (!in_reset) last_grant <= 1'b1;
        else if (start) last_grant <= pick_core;
    end
`else
    assign pick_core = core_ok & ~host_ok;
`endif
    assign start    = (state == IDLE) & (host_ok | core_ok);
    assign sel_we   = pick_core ? in_core_we : in_host_we;
    assign sel_addr = pick_core ? in_core_addr : in_host_addr;
    assign req_err  = (sel_addr > max_addr) | (pick_core & sel_we & (sel_addr < log_size'(2)));
    assign done     = state == DONE;
    assign out_busy                = state != IDLE;
    assign out_mem_read_en         = (state == ISSUE) & ~we_r;
    assign out_mem_write_en        = (state == ISSUE) & we_r;
    assign out_host_ack            = done & ~grant_r;
    assign out_core_ack            = done & grant_r;
    assign out_host_err            = out_host_ack & err_r;
    assign out_core_err            = out_core_ack & err_r;
    assign out_host_rdata          = out_host_ack ? rdata_r : '0;
    assign out_core_rdata          = out_core_ack ? rdata_r : '0;
    assign out_mem_write_status_en = done;
    assign out_mem_status          = done ? cell_width'({14'b0, grant_r, err_r, txn_count + 16'd1}) : '0;
    // state register
    always_ff @(posedge in_clk) begin
        if (!in_reset) state <= IDLE;
        else state <= state_nxt;
    end
    // next state: rejected requests skip the memory and complete immediately
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? (req_err ? DONE : ISSUE) : IDLE;
            ISSUE:   state_nxt = we_r ? DONE : WAIT;
            WAIT:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // latch the winner, drive the memory port, capture read data and count completions
    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            we_r            <= 1'b0;
            grant_r         <= 1'b0;
            err_r           <= 1'b0;
            rdata_r         <= '0;
            txn_count       <= '0;
            out_mem_address <= '0;
            out_mem_data    <= '0;
        end else begin
            if (start) begin
                we_r    <= sel_we;
                grant_r <= pick_core;
                err_r   <= req_err;
                rdata_r <= '0;
                if (!req_err) begin
                    out_mem_address <= sel_addr;
                    out_mem_data    <= pick_core ? in_core_wdata : in_host_wdata;
                end
            end
            if (state == WAIT) rdata_r <= in_mem_data;
            if (done) txn_count <= txn_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a registered memory model
module tb_mem_arbiter;
    localparam int W = 128;
    typedef struct {
        bit          core;
        bit          err;
        logic [W-1:0] rdata;
        logic [31:0] status;
    } exp_t;

    logic          in_clk = 0, in_reset = 0;
    logic          in_host_req = 0, in_host_we = 0, in_core_req = 0, in_core_we = 0;
    logic [9:0]    in_host_addr = 0, in_core_addr = 0;
    logic [W-1:0]  in_host_wdata = 0, in_core_wdata = 0;
    logic          out_host_ack, out_host_err, out_core_ack, out_core_err;
    logic [W-1:0]  out_host_rdata, out_core_rdata, out_mem_data, in_mem_data;
    logic [9:0]    out_mem_address;
    logic          out_mem_read_en, out_mem_write_en, out_mem_write_status_en, out_busy;
    logic [31:0]   out_mem_status, in_mem_config = 0;

    int checks = 0, errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [15:0] exp_cnt = 0;
    logic [W-1:0] mem [0:1023];
    logic [W-1:0] shadow [0:1023];
    int lat, ec, ew;
    logic [9:0] ea;

    mem_arbiter dut (
        .in_clk(in_clk), .in_reset(in_reset),
        .in_host_req(in_host_req), .in_host_we(in_host_we), .in_host_addr(in_host_addr), .in_host_wdata(in_host_wdata),
        .in_core_req(in_core_req), .in_core_we(in_core_we), .in_core_addr(in_core_addr), .in_core_wdata(in_core_wdata),
        .out_host_ack(out_host_ack), .out_host_err(out_host_err), .out_host_rdata(out_host_rdata),
        .out_core_ack(out_core_ack), .out_core_err(out_core_err), .out_core_rdata(out_core_rdata),
        .out_mem_address(out_mem_address), .out_mem_data(out_mem_data),
        .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
        .out_mem_status(out_mem_status), .out_mem_write_status_en(out_mem_write_status_en),
        .in_mem_data(in_mem_data), .in_mem_config(in_mem_config), .out_busy(out_busy)
    );

    always #5 in_clk = ~in_clk;

    // memory instance model: registered read, one cycle latency
    always @(posedge in_clk) begin
        if (out_mem_write_en) mem[out_mem_address] <= out_mem_data;
        if (out_mem_read_en) in_mem_data <= mem[out_mem_address];
    end

    // scoreboard: every ack pops the oldest expectation
    always @(negedge in_clk) begin
        if (in_reset && (out_host_ack || out_core_ack)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack host=%0b core=%0b", out_host_ack, out_core_ack);
            end else begin
                mon_e = sb.pop_front();
                if ({out_core_ack, out_host_ack} !== {mon_e.core, !mon_e.core}) begin
                    errors++;
                    $display("FAIL ack_who got core=%0b host=%0b want core=%0b", out_core_ack, out_host_ack, mon_e.core);
                end
                checks++;
                if ({out_core_err, out_host_err} !== {mon_e.core & mon_e.err, !mon_e.core & mon_e.err}) begin
                    errors++;
                    $display("FAIL ack_err got core=%0b host=%0b want err=%0b", out_core_err, out_host_err, mon_e.err);
                end
                checks++;
                if ((mon_e.core ? out_core_rdata : out_host_rdata) !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL rdata got %h want %h", mon_e.core ? out_core_rdata : out_host_rdata, mon_e.rdata);
                end
                checks++;
                if ({out_mem_write_status_en, out_mem_status} !== {1'b1, mon_e.status}) begin
                    errors++;
                    $display("FAIL status got en=%0b %h want en=1 %h", out_mem_write_status_en, out_mem_status, mon_e.status);
                end
            end
        end
    end

    task automatic push_exp(input bit core, input bit we, input logic [9:0] addr, input logic [W-1:0] wd, input bit err);
        exp_t e;
        e.core = core;
        e.err = err;
        e.rdata = (we || err) ? '0 : shadow[addr];
        exp_cnt = exp_cnt + 16'd1;
        e.status = {14'b0, core, err, exp_cnt};
        if (we && !err) shadow[addr] = wd;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        in_reset = 0;
        in_host_req = 0;
        in_core_req = 0;
        repeat (2) @(negedge in_clk);
        in_reset = 1;
        exp_cnt = 0;
        sb.delete();
    endtask

    // one transaction from IDLE; lat/en_cyc are negedges after the request (-1 = not seen)
    task automatic txn(input bit core, input bit we, input logic [9:0] addr, input logic [W-1:0] wd, input bit err,
                       output int l, output int en_cyc, output int en_we, output logic [9:0] en_addr);
        push_exp(core, we, addr, wd, err);
        if (core) begin
            in_core_we = we; in_core_addr = addr; in_core_wdata = wd; in_core_req = 1;
        end else begin
            in_host_we = we; in_host_addr = addr; in_host_wdata = wd; in_host_req = 1;
        end
        l = -1; en_cyc = -1; en_we = -1; en_addr = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge in_clk);
            if ((out_mem_read_en || out_mem_write_en) && en_cyc < 0) begin
                en_cyc = c; en_we = int'(out_mem_write_en); en_addr = out_mem_address;
            end
            if (core ? out_core_ack : out_host_ack) begin
                l = c;
                break;
            end
        end
        in_core_req = 0;
        in_host_req = 0;
        @(negedge in_clk);
    endtask

    task automatic test_reset();
        do_reset();
        in_reset = 0;
        @(negedge in_clk);
        checks++;
        if ({out_busy, out_host_ack, out_core_ack, out_host_err, out_core_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {out_busy, out_host_ack, out_core_ack, out_host_err, out_core_err});
        end
        checks++;
        if ({out_host_rdata, out_core_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_rdata got %h %h want 0", out_host_rdata, out_core_rdata);
        end
        checks++;
        if ({out_mem_address, out_mem_data, out_mem_read_en, out_mem_write_en, out_mem_status, out_mem_write_status_en} !== '0) begin
            errors++;
            $display("FAIL reset_mem got addr=%h data=%h re=%b we=%b st=%h sen=%b want all 0",
                     out_mem_address, out_mem_data, out_mem_read_en, out_mem_write_en, out_mem_status, out_mem_write_status_en);
        end
        in_reset = 1;
        @(negedge in_clk);
    endtask

    task automatic test_host_write();
        txn(0, 1, 10'd8, 128'h0123_4567_89AB_CDEF_DDDD_CCCC_BBBB_AAAA, 0, lat, ec, ew, ea);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL host_write_latency got %0d want 2", lat); end
        checks++;
        if ({ec, ew, ea} !== {32'd1, 32'd1, 10'd8}) begin
            errors++;
            $display("FAIL host_write_issue got cyc=%0d we=%0d addr=%0d want cyc=1 we=1 addr=8", ec, ew, ea);
        end
    endtask

    task automatic test_host_read();
        txn(0, 0, 10'd8, '0, 0, lat, ec, ew, ea);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL host_read_latency got %0d want 3", lat); end
        checks++;
        if ({ec, ew, ea} !== {32'd1, 32'd0, 10'd8}) begin
            errors++;
            $display("FAIL host_read_issue got cyc=%0d we=%0d addr=%0d want cyc=1 we=0 addr=8", ec, ew, ea);
        end
    endtask

    task automatic test_core_err();
        in_mem_config = 32'h1;
        txn(1, 1, 10'd1, 128'hDEAD, 1, lat, ec, ew, ea);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL core_err_latency got %0d want 1", lat); end
        checks++;
        if (ec !== -1) begin errors++; $display("FAIL core_err_no_access got enable at cycle %0d want none", ec); end
    endtask

    task automatic test_cfg_gate();
        bit bad = 0;
        in_mem_config = 32'h0;
        in_core_we = 1; in_core_addr = 10'd16; in_core_wdata = 128'h1616; in_core_req = 1;
        repeat (10) begin
            @(negedge in_clk);
            if (out_busy || out_core_ack) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL cfg_gate got busy/ack while config[0]=0 want idle"); end
        push_exp(1, 1, 10'd16, 128'h1616, 0);
        in_mem_config = 32'h1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge in_clk);
            if (out_core_ack) begin lat = c; break; end
        end
        in_core_req = 0;
        @(negedge in_clk);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL cfg_gate_grant got latency %0d want 2", lat); end
    endtask

    task automatic test_boundary();
        txn(0, 0, 10'd1021, '0, 1, lat, ec, ew, ea);
        checks++;
        if ({lat, ec} !== {32'd1, -32'sd1}) begin
            errors++;
            $display("FAIL addr_1021 got latency=%0d enable_cycle=%0d want 1 and none", lat, ec);
        end
        txn(0, 0, 10'd1020, '0, 0, lat, ec, ew, ea);
        checks++;
        if ({lat, ea} !== {32'd3, 10'd1020}) begin
            errors++;
            $display("FAIL addr_1020 got latency=%0d addr=%0d want 3 1020", lat, ea);
        end
        txn(1, 0, 10'd1, '0, 0, lat, ec, ew, ea);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL core_read_addr1 got latency %0d want 3", lat); end
        txn(1, 1, 10'd2, 128'h2222, 0, lat, ec, ew, ea);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL core_write_addr2 got latency %0d want 2", lat); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        in_mem_config = 32'h1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (i % 2 == 0) push_exp(0, 1, 10'd100, 128'hA100, 0);
            else push_exp(1, 1, 10'd200, 128'hC200, 0);
`else
            push_exp(0, 1, 10'd100, 128'hA100, 0);
`endif
        end
        in_host_we = 1; in_host_addr = 10'd100; in_host_wdata = 128'hA100;
        in_core_we = 1; in_core_addr = 10'd200; in_core_wdata = 128'hC200;
        in_host_req = 1; in_core_req = 1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge in_clk);
            if (out_host_ack || out_core_ack) n++;
        end
        in_host_req = 0; in_core_req = 0;
        @(negedge in_clk);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL back_to_back_acks got %0d want 4", n); end
    endtask

    task automatic test_reset_mid();
        in_host_we = 0; in_host_addr = 10'd8; in_host_req = 1;
        repeat (2) @(negedge in_clk);
        checks++;
        if (out_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", out_busy); end
        in_reset = 0;
        in_host_req = 0;
        @(negedge in_clk);
        checks++;
        if ({out_busy, out_host_ack, out_mem_address, out_mem_read_en, out_mem_write_status_en, out_host_rdata} !== '0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b ack=%b addr=%0d re=%b sen=%b rdata=%h want all 0",
                     out_busy, out_host_ack, out_mem_address, out_mem_read_en, out_mem_write_status_en, out_host_rdata);
        end
        in_reset = 1;
        exp_cnt = 0;
        @(negedge in_clk);
        txn(0, 1, 10'd12, 128'h1212, 0, lat, ec, ew, ea);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL after_reset_write got latency %0d want 2", lat); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        in_mem_data = '0;
        test_reset();
        test_host_write();
        test_host_read();
        test_core_err();
        test_cfg_gate();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge in_clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL pending_acks got %0d outstanding want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end
endmodule
